// File: rtl/mult_sequencer_if.sv
// Control bundle between mult_sequencer and the Booth multiplier datapath / BCD converter.
interface mult_sequencer_if #(
    parameter int unsigned CNT_W = 3
);
    logic             start;
    logic             qn;
    logic             qlsb;
    logic             bcd_rdy;
    logic             ld_init;
    logic             acc_en;
    logic             acc_sub;
    logic             ashr_en;
    logic             res_en;
    logic             bcd_en;
    logic [CNT_W-1:0] cnt;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, qn, qlsb, bcd_rdy,
        input  ld_init, acc_en, acc_sub, ashr_en, res_en, bcd_en, cnt, busy, done, err
    );

    modport slave (
        input  start, qn, qlsb, bcd_rdy,
        output ld_init, acc_en, acc_sub, ashr_en, res_en, bcd_en, cnt, busy, done, err
    );
endinterface

// File: rtl/mult_sequencer.sv
// Radix-2 Booth sequential multiplier controller: iteration sequencing, result latch, BCD handoff.
// Optional START_EDGE_EN: start is synchronized and edge-detected instead of level-sampled.
module mult_sequencer #(
    parameter int unsigned WIDTH_MUL   = 5,
    parameter int unsigned CNT_W       = 3,
    parameter int unsigned BCD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             rst,
    mult_sequencer_if.slave  bus
);

    localparam int unsigned TMO_W = (BCD_TIMEOUT > 2) ? $clog2(BCD_TIMEOUT) : 1;

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_LOAD   = 4'd1,
        S_EVAL   = 4'd2,
        S_ADD    = 4'd3,
        S_SUB    = 4'd4,
        S_SHIFT  = 4'd5,
        S_RESULT = 4'd6,
        S_BCD    = 4'd7,
        S_DONE   = 4'd8
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    logic               err_q, err_d;
    logic               ld_init_q, ld_init_d;
    logic               acc_en_q, acc_en_d;
    logic               acc_sub_q, acc_sub_d;
    logic               ashr_en_q, ashr_en_d;
    logic               res_en_q, res_en_d;
    logic               bcd_en_q, bcd_en_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               start_acc_c;

`ifdef START_EDGE_EN
    // Two flops of synchronization, third flop holds the previous level for edge detection.
    logic [2:0] start_sync_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) start_sync_q <= 3'b000;
        else      start_sync_q <= {start_sync_q[1:0], bus.start};
    end

    assign start_acc_c = start_sync_q[1] & ~start_sync_q[2];
`else
    assign start_acc_c = bus.start;
`endif

    // Next state, counters and registered Moore outputs decoded from the next state.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        err_d     = err_q;
        ld_init_d = 1'b0;
        acc_en_d  = 1'b0;
        acc_sub_d = 1'b0;
        ashr_en_d = 1'b0;
        res_en_d  = 1'b0;
        bcd_en_d  = 1'b0;
        busy_d    = 1'b1;
        done_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_acc_c) begin
                    state_d = S_LOAD;
                    err_d   = 1'b0;
                end
            end
            S_LOAD: begin
                cnt_d   = '0;
                state_d = S_EVAL;
            end
            S_EVAL: begin
                case ({bus.qlsb, bus.qn})
                    2'b10:   state_d = S_SUB;
                    2'b01:   state_d = S_ADD;
                    default: state_d = S_SHIFT;
                endcase
            end
            S_ADD, S_SUB: state_d = S_SHIFT;
            S_SHIFT: begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = (cnt_q == CNT_W'(WIDTH_MUL - 1)) ? S_RESULT : S_EVAL;
            end
            S_RESULT: begin
                tmo_d   = '0;
                state_d = S_BCD;
            end
            S_BCD: begin
                // Ready wins over a simultaneous timeout.
                if (bus.bcd_rdy) begin
                    state_d = S_DONE;
                end else if (tmo_q == TMO_W'(BCD_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        case (state_d)
            S_IDLE:   busy_d    = 1'b0;
            S_LOAD:   ld_init_d = 1'b1;
            S_ADD:    acc_en_d  = 1'b1;
            S_SUB: begin
                acc_en_d  = 1'b1;
                acc_sub_d = 1'b1;
            end
            S_SHIFT:  ashr_en_d = 1'b1;
            S_RESULT: res_en_d  = 1'b1;
            S_BCD:    bcd_en_d  = 1'b1;
            S_DONE:   done_d    = 1'b1;
            default:  busy_d    = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            tmo_q     <= '0;
            err_q     <= 1'b0;
            ld_init_q <= 1'b0;
            acc_en_q  <= 1'b0;
            acc_sub_q <= 1'b0;
            ashr_en_q <= 1'b0;
            res_en_q  <= 1'b0;
            bcd_en_q  <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            err_q     <= err_d;
            ld_init_q <= ld_init_d;
            acc_en_q  <= acc_en_d;
            acc_sub_q <= acc_sub_d;
            ashr_en_q <= ashr_en_d;
            res_en_q  <= res_en_d;
            bcd_en_q  <= bcd_en_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.ld_init = ld_init_q;
    assign bus.acc_en  = acc_en_q;
    assign bus.acc_sub = acc_sub_q;
    assign bus.ashr_en = ashr_en_q;
    assign bus.res_en  = res_en_q;
    assign bus.bcd_en  = bcd_en_q;
    assign bus.cnt     = cnt_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.err     = err_q;

endmodule

// File: tb/tb_mult_sequencer.sv
// Scoreboard bench for mult_sequencer with a Booth datapath shift model and a BCD converter stub.
module tb_mult_sequencer;

    localparam int unsigned WIDTH_MUL = 5;
    localparam int unsigned CNT_W     = 3;

    typedef struct {
        int lat;
        int n_acc;
        int seq;
        int n_shr;
        int n_res;
        int n_bcd;
        int err;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    mult_sequencer_if #(.CNT_W(CNT_W)) bus ();

    mult_sequencer #(
        .WIDTH_MUL  (WIDTH_MUL),
        .CNT_W      (CNT_W),
        .BCD_TIMEOUT(64)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_push = 0;
    int   n_done = 0;
    exp_t exp_q[$];

    logic [4:0] dp_mult = '0;
    logic [5:0] dpq     = '0;
    int         bcd_hi  = 0;
    int         rdy_thr = 2;

    task automatic check(input string name, input int act, input int expv);
        n_chk++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
        end
    endtask

    function automatic int outs();
        return int'({bus.ld_init, bus.acc_en, bus.acc_sub, bus.ashr_en, bus.res_en,
                     bus.bcd_en, bus.busy, bus.done, bus.err, bus.cnt});
    endfunction

    // Datapath model: {Q, Qn} loaded with {multiplier, 0}, shifted right on each ashr_en.
    always @(negedge clk) begin
        if (bus.ld_init)      dpq = {dp_mult, 1'b0};
        else if (bus.ashr_en) dpq = {1'b0, dpq[5:1]};
        bus.qn   = dpq[0];
        bus.qlsb = dpq[1];
    end

    // BCD stub: rdy rises once bcd_en has been high for rdy_thr sampled cycles.
    always @(negedge clk) begin
        if (bus.bcd_en) bcd_hi++;
        else            bcd_hi = 0;
        bus.bcd_rdy = (bcd_hi >= rdy_thr);
    end

    // Monitor: accumulates per-operation activity and scores it on done.
    int lat = 0, n_acc = 0, seq = 0, n_shr = 0, n_res = 0, n_bcd = 0, n_ld = 0;
    always @(negedge clk) begin
        if (!rst) begin
            lat = 0; n_acc = 0; seq = 0; n_shr = 0; n_res = 0; n_bcd = 0; n_ld = 0;
        end else if (bus.busy) begin
            lat++;
            if (bus.acc_en) begin
                n_acc++;
                seq = (seq << 1) | int'(bus.acc_sub);
            end
            if (bus.ashr_en) n_shr++;
            if (bus.res_en)  n_res++;
            if (bus.bcd_en)  n_bcd++;
            if (bus.ld_init) n_ld++;
            if (bus.done) begin
                exp_t e;
                n_done++;
                if (exp_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("latency", lat, e.lat);
                    check("acc_en_count", n_acc, e.n_acc);
                    check("acc_sub_seq", seq, e.seq);
                    check("ashr_en_count", n_shr, e.n_shr);
                    check("res_en_count", n_res, e.n_res);
                    check("bcd_en_cycles", n_bcd, e.n_bcd);
                    check("ld_init_count", n_ld, 1);
                    check("err_at_done", int'(bus.err), e.err);
                    check("cnt_at_done", int'(bus.cnt), 5);
                end
                lat = 0; n_acc = 0; seq = 0; n_shr = 0; n_res = 0; n_bcd = 0; n_ld = 0;
            end
        end
    end

    task automatic push(input int l, input int a, input int s, input int b, input int er);
        exp_t e;
        e.lat = l; e.n_acc = a; e.seq = s; e.n_shr = 5; e.n_res = 1; e.n_bcd = b; e.err = er;
        exp_q.push_back(e);
        n_push++;
    endtask

    task automatic pulse_start();
        @(negedge clk) bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        int n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            check("drain_timeout", exp_q.size(), 0);
            exp_q.delete();
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_op(input logic [4:0] m, input int l, input int a, input int s,
                          input int b, input int er);
        dp_mult = m;
        push(l, a, s, b, er);
        pulse_start();
        wait_drain(300);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k, n;
        bus.start   = 1'b0;
        bus.qn      = 1'b0;
        bus.qlsb    = 1'b0;
        bus.bcd_rdy = 1'b0;
        rst         = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_outputs", outs(), 0);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);

        // Booth patterns: latency = 1 + 10 + A + 1 + 2 + 1
        run_op(5'b00000, 15, 0, 0,    2, 0);
        run_op(5'b00001, 17, 2, 2,    2, 0);
        run_op(5'b10101, 20, 5, 'h15, 2, 0);
        run_op(5'b11111, 16, 1, 1,    2, 0);
        run_op(5'b01110, 17, 2, 2,    2, 0);

        // Ready on the final allowed BCD cycle is success; never ready is a timeout.
        rdy_thr = 64;
        run_op(5'b00000, 77, 0, 0, 64, 0);
        rdy_thr = 1000;
        run_op(5'b00000, 77, 0, 0, 64, 1);
        check("err_sticky_idle", int'(bus.err), 1);
        rdy_thr = 2;
        run_op(5'b00000, 15, 0, 0, 2, 0);
        check("err_cleared", int'(bus.err), 0);

        // Abort with reset during the third shift.
        dp_mult = 5'b00000;
        pulse_start();
        k = 0; n = 0;
        while (k < 3 && n < 100) begin
            @(negedge clk);
            n++;
            if (bus.ashr_en) k++;
        end
        check("reached_3rd_shift", k, 3);
        rst = 1'b0;
        #1;
        check("abort_outputs", outs(), 0);
        @(negedge clk);
        @(negedge clk) rst = 1'b1;
        repeat (2) @(negedge clk);
        check("idle_after_abort", int'(bus.busy), 0);
        run_op(5'b00000, 15, 0, 0, 2, 0);

        // Start pulses while busy (and in the DONE cycle) are ignored.
        dp_mult = 5'b00000;
        push(15, 0, 0, 2, 0);
        pulse_start();
        repeat (4) @(negedge clk);
        pulse_start();
        repeat (3) @(negedge clk);
        pulse_start();
`ifndef START_EDGE_EN
        n = 0;
        while (!bus.done && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("saw_done_for_pulse", int'(bus.done), 1);
        bus.start = 1'b1;
        @(negedge clk) bus.start = 1'b0;
`endif
        wait_drain(300);
        repeat (30) @(negedge clk);

        // Start held high for 40 cycles.
        dp_mult = 5'b00000;
`ifdef START_EDGE_EN
        push(15, 0, 0, 2, 0);
`else
        push(15, 0, 0, 2, 0);
        push(15, 0, 0, 2, 0);
        push(15, 0, 0, 2, 0);
`endif
        @(negedge clk) bus.start = 1'b1;
        repeat (40) @(negedge clk);
        bus.start = 1'b0;
        wait_drain(300);
        repeat (20) @(negedge clk);

        // A fresh rising edge gives exactly one more operation.
        run_op(5'b00001, 17, 2, 2, 2, 0);
        repeat (20) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        check("done_count", n_done, n_push);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
